// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package icache_pkg;
  localparam int ADDR_W              = 32;
  localparam int DATA_W              = 32;
  localparam int DEFAULT_INDEX_WIDTH = 8;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_MISS = 2'd1,
    ICACHE_DROP = 2'd2
  } icache_state_e;
endpackage

// File: rtl/icache_if.sv
// Fetch-side and memCtrl-side signals of the instruction cache.
interface icache_if;
  import icache_pkg::*;

  // Handshakes: fe_to_ic_enable/pc are held until a one-cycle ic_to_fe_done
  // pulse; ic_to_mc_enable/pc are held until a one-cycle mc_to_ic_done pulse,
  // and enable falls on the following cycle. One request in flight per side.
  logic              fe_to_ic_enable;
  logic [ADDR_W-1:0] fe_to_ic_pc;
  logic              ic_to_fe_done;
  logic [DATA_W-1:0] ic_to_fe_inst;
  logic              ic_to_mc_enable;
  logic [ADDR_W-1:0] ic_to_mc_pc;
  logic              mc_to_ic_done;
  logic [DATA_W-1:0] mc_to_ic_result;

  modport master (
    output fe_to_ic_enable, fe_to_ic_pc, mc_to_ic_done, mc_to_ic_result,
    input  ic_to_fe_done, ic_to_fe_inst, ic_to_mc_enable, ic_to_mc_pc
  );

  modport slave (
    input  fe_to_ic_enable, fe_to_ic_pc, mc_to_ic_done, mc_to_ic_result,
    output ic_to_fe_done, ic_to_fe_inst, ic_to_mc_enable, ic_to_mc_pc
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, single-word refill through memCtrl,
// flush drops the pending reply but always lets an issued refill complete.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clr,
  icache_if.slave       bus,
  output icache_state_e state
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_W - 2 - INDEX_WIDTH;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  icache_state_e     state_q, state_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              mc_en_q, mc_en_d;
  logic [ADDR_W-3:0] req_q, req_d;
  logic              fill;

  logic [INDEX_WIDTH-1:0] fe_index, req_index;
  logic [TAG_W-1:0]       fe_tag, req_tag;
  logic                   hit;
  logic                   unused_pc_bits;

  assign fe_index       = bus.fe_to_ic_pc[INDEX_WIDTH+1:2];
  assign fe_tag         = bus.fe_to_ic_pc[ADDR_W-1:INDEX_WIDTH+2];
  assign req_index      = req_q[INDEX_WIDTH-1:0];
  assign req_tag        = req_q[ADDR_W-3:INDEX_WIDTH];
  assign hit            = valid_q[fe_index] && (tag_q[fe_index] == fe_tag);
  assign unused_pc_bits = ^bus.fe_to_ic_pc[1:0];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    inst_d  = '0;
    mc_en_d = mc_en_q;
    req_d   = req_q;
    fill    = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        // The cycle after a done pulse is a bubble so a held request is not served twice.
        if (bus.fe_to_ic_enable && !clr && !done_q) begin
          if (hit) begin
            done_d = 1'b1;
            inst_d = data_q[fe_index];
          end else begin
            mc_en_d = 1'b1;
            req_d   = bus.fe_to_ic_pc[ADDR_W-1:2];
            state_d = ICACHE_MISS;
          end
        end
      end
      ICACHE_MISS: begin
        if (bus.mc_to_ic_done) begin
          fill    = 1'b1;
          mc_en_d = 1'b0;
          state_d = ICACHE_IDLE;
          if (!clr) begin
            done_d = 1'b1;
            inst_d = bus.mc_to_ic_result;
          end
        end else if (clr) begin
          state_d = ICACHE_DROP;
        end
      end
      ICACHE_DROP: begin
        if (bus.mc_to_ic_done) begin
          fill    = 1'b1;
          mc_en_d = 1'b0;
          state_d = ICACHE_IDLE;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ICACHE_IDLE;
      done_q  <= 1'b0;
      inst_q  <= '0;
      mc_en_q <= 1'b0;
      req_q   <= '0;
      valid_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
      mc_en_q <= mc_en_d;
      req_q   <= req_d;
      if (fill) valid_q[req_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      data_q[req_index] <= bus.mc_to_ic_result;
      tag_q[req_index]  <= req_tag;
    end
  end

  // A pending pulse stays registered while frozen and shows again once rdy returns.
  assign bus.ic_to_fe_done   = done_q & rdy;
  assign bus.ic_to_fe_inst   = (done_q && rdy) ? inst_q : '0;
  assign bus.ic_to_mc_enable = mc_en_q;
  assign bus.ic_to_mc_pc     = {req_q, 2'b00};
  assign state               = state_q;
endmodule
